// File: rtl/netlist_writer.sv
// netlist_writer: packs a stream of gate descriptors into the 32-bit netlist
// memory image read by the garbling netlist reader. Three header words go to
// addresses 0..2, gate words go from address 4 upward, and the trailer word
// (xor_count, gate_count) goes to address 3 once the last gate is written.
module netlist_writer #(
    parameter int S = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [S-1:0] init_a,
    input  logic [S-1:0] init_b,
    input  logic [S-1:0] input_a,
    input  logic [S-1:0] input_b,
    input  logic [S-1:0] dff_size,
    input  logic [S-1:0] output_size,
    input  logic         g_valid,
    output logic         g_ready,
    input  logic [S-1:0] g_in0,
    input  logic [S-1:0] g_in1,
    input  logic [3:0]   g_logic,
    input  logic         g_is_output,
    input  logic         g_last,
    output logic         mem_we,
    output logic [S-1:0] mem_addr,
    output logic [31:0]  mem_wdata,
    output logic         done,
    output logic [S-1:0] gate_count,
    output logic [S-1:0] xor_count,
    output logic         err_in0,
    output logic         err_full
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR0    = 3'd1,
        HDR1    = 3'd2,
        HDR2    = 3'd3,
        GATES   = 3'd4,
        TRAILER = 3'd5,
        DONE    = 3'd6
    } state_t;

    // Gate words start after the three header words and the trailer slot.
    localparam logic [S-1:0] ADDR_HDR0  = {S{1'b0}};
    localparam logic [S-1:0] ADDR_HDR1  = {{(S-2){1'b0}}, 2'd1};
    localparam logic [S-1:0] ADDR_HDR2  = {{(S-2){1'b0}}, 2'd2};
    localparam logic [S-1:0] ADDR_TRL   = {{(S-2){1'b0}}, 2'd3};
    localparam logic [S-1:0] GATE_BASE  = {{(S-3){1'b0}}, 3'd4};
    localparam logic [S-1:0] COUNT_ONE  = {{(S-1){1'b0}}, 1'b1};
    // Count value just before the last free gate slot (2^S-5).
    localparam logic [S-1:0] LAST_SLOT  = {{(S-3){1'b1}}, 3'b011};

    // Two S-bit fields packed into one word, upper bits zero.
    function automatic logic [31:0] pack_pair(input logic [S-1:0] hi, input logic [S-1:0] lo);
        pack_pair = (32'(hi) << S) | 32'(lo);
    endfunction

    // Gate word layout decoded by the netlist reader; in0 loses its top bit.
    function automatic logic [31:0] pack_gate(input logic [S-1:0] in0, input logic [S-1:0] in1,
                                              input logic [3:0] lg, input logic is_out);
        pack_gate = (32'(in0[S-2:0]) << (S + 5)) | (32'(in1) << 5) | (32'(lg) << 1) | 32'(is_out);
    endfunction

    state_t       state_r, state_nxt_s;
    logic [S-1:0] input_a_r, input_b_r, dff_size_r, output_size_r;
    logic [S-1:0] gate_count_r, xor_count_r;
    logic         err_in0_r, err_full_r;
    // fin_r: final gate accepted, trailer is written on the next cycle.
    logic         fin_r, fin_nxt_s, fin_set_s;
    logic         xfer_s, at_cap_s, is_xor_s, start_ok_s;
    logic         we_r, we_nxt_s;
    logic [S-1:0] addr_r, addr_nxt_s;
    logic [31:0]  wdata_r, wdata_nxt_s;
    logic         ready_r, ready_nxt_s;
    logic         done_r, done_nxt_s;

    assign start_ok_s = (state_r == IDLE) & start;
    assign xfer_s     = g_valid & ready_r;
    assign at_cap_s   = (gate_count_r == LAST_SLOT);
    assign is_xor_s   = (g_logic == 4'b0110) | (g_logic == 4'b1001);
    assign fin_set_s  = xfer_s & (g_last | at_cap_s);
    assign fin_nxt_s  = start_ok_s ? 1'b0 : (fin_r | fin_set_s);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: header sequence, gate stream, trailer, done pulse.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = HDR0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HDR0:    state_nxt_s = HDR1;
            HDR1:    state_nxt_s = HDR2;
            HDR2:    state_nxt_s = GATES;
            GATES: begin
                if (fin_r) begin
                    state_nxt_s = TRAILER;
                end else begin
                    state_nxt_s = GATES;
                end
            end
            TRAILER: state_nxt_s = DONE;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output logic: the write for the cycle a state is entered, plus ready/done.
    always_comb begin
        we_nxt_s    = 1'b0;
        addr_nxt_s  = {S{1'b0}};
        wdata_nxt_s = 32'd0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    we_nxt_s    = 1'b1;
                    addr_nxt_s  = ADDR_HDR0;
                    wdata_nxt_s = pack_pair(init_a, init_b);
                end else begin
                    we_nxt_s    = 1'b0;
                end
            end
            HDR0: begin
                we_nxt_s    = 1'b1;
                addr_nxt_s  = ADDR_HDR1;
                wdata_nxt_s = pack_pair(input_a_r, input_b_r);
            end
            HDR1: begin
                we_nxt_s    = 1'b1;
                addr_nxt_s  = ADDR_HDR2;
                wdata_nxt_s = pack_pair(dff_size_r, output_size_r);
            end
            GATES: begin
                if (fin_r) begin
                    we_nxt_s    = 1'b1;
                    addr_nxt_s  = ADDR_TRL;
                    wdata_nxt_s = pack_pair(xor_count_r, gate_count_r);
                end else if (xfer_s) begin
                    we_nxt_s    = 1'b1;
                    addr_nxt_s  = gate_count_r + GATE_BASE;
                    wdata_nxt_s = pack_gate(g_in0, g_in1, g_logic, g_is_output);
                end else begin
                    we_nxt_s    = 1'b0;
                end
            end
            default: begin
                we_nxt_s = 1'b0;
            end
        endcase
        ready_nxt_s = (state_nxt_s == GATES) & ~fin_nxt_s;
        done_nxt_s  = (state_nxt_s == DONE);
    end

    // Registered memory port, handshake and done outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r    <= 1'b0;
            addr_r  <= {S{1'b0}};
            wdata_r <= 32'd0;
            ready_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            we_r    <= we_nxt_s;
            addr_r  <= addr_nxt_s;
            wdata_r <= wdata_nxt_s;
            ready_r <= ready_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Header latches, gate/xor counters, sticky error flags and finish flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            input_a_r     <= {S{1'b0}};
            input_b_r     <= {S{1'b0}};
            dff_size_r    <= {S{1'b0}};
            output_size_r <= {S{1'b0}};
            gate_count_r  <= {S{1'b0}};
            xor_count_r   <= {S{1'b0}};
            err_in0_r     <= 1'b0;
            err_full_r    <= 1'b0;
            fin_r         <= 1'b0;
        end else if (start_ok_s) begin
            input_a_r     <= input_a;
            input_b_r     <= input_b;
            dff_size_r    <= dff_size;
            output_size_r <= output_size;
            gate_count_r  <= {S{1'b0}};
            xor_count_r   <= {S{1'b0}};
            err_in0_r     <= 1'b0;
            err_full_r    <= 1'b0;
            fin_r         <= 1'b0;
        end else if (xfer_s) begin
            gate_count_r  <= gate_count_r + COUNT_ONE;
            xor_count_r   <= is_xor_s ? (xor_count_r + COUNT_ONE) : xor_count_r;
            err_in0_r     <= err_in0_r | g_in0[S-1];
            err_full_r    <= err_full_r | (at_cap_s & ~g_last);
            fin_r         <= fin_nxt_s;
        end else begin
            fin_r         <= fin_r;
        end
    end

    assign mem_we     = we_r;
    assign mem_addr   = addr_r;
    assign mem_wdata  = wdata_r;
    assign g_ready    = ready_r;
    assign done       = done_r;
    assign gate_count = gate_count_r;
    assign xor_count  = xor_count_r;
    assign err_in0    = err_in0_r;
    assign err_full   = err_full_r;

endmodule

// File: tb/tb_netlist_writer.sv
// Directed bench for netlist_writer: header words, single gate, streaming,
// random stalls, error flags (S=14 and a small S=4 instance) and mid-run reset.
module tb_netlist_writer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // S=14 instance signals
    logic        start = 1'b0;
    logic [13:0] init_a = 14'd0, init_b = 14'd0, input_a = 14'd0, input_b = 14'd0;
    logic [13:0] dff_size = 14'd0, output_size = 14'd0;
    logic        g_valid = 1'b0, g_is_output = 1'b0, g_last = 1'b0;
    logic [13:0] g_in0 = 14'd0, g_in1 = 14'd0;
    logic [3:0]  g_logic = 4'd0;
    logic        g_ready, mem_we, done, err_in0, err_full;
    logic [13:0] mem_addr, gate_count, xor_count;
    logic [31:0] mem_wdata;

    // S=4 instance signals
    logic        s4_start = 1'b0;
    logic [3:0]  s4_zero = 4'd0;
    logic        s4_valid = 1'b0, s4_last = 1'b0;
    logic [3:0]  s4_in0 = 4'd0, s4_in1 = 4'd0, s4_logic = 4'd0;
    logic        s4_ready, s4_we, s4_done, s4_err_in0, s4_err_full;
    logic [3:0]  s4_addr, s4_gc, s4_xc;
    logic [31:0] s4_wdata;

    netlist_writer #(.S(14)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .init_a(init_a), .init_b(init_b), .input_a(input_a), .input_b(input_b),
        .dff_size(dff_size), .output_size(output_size),
        .g_valid(g_valid), .g_ready(g_ready), .g_in0(g_in0), .g_in1(g_in1),
        .g_logic(g_logic), .g_is_output(g_is_output), .g_last(g_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done),
        .gate_count(gate_count), .xor_count(xor_count),
        .err_in0(err_in0), .err_full(err_full)
    );

    netlist_writer #(.S(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4_start),
        .init_a(s4_zero), .init_b(s4_zero), .input_a(s4_zero), .input_b(s4_zero),
        .dff_size(s4_zero), .output_size(s4_zero),
        .g_valid(s4_valid), .g_ready(s4_ready), .g_in0(s4_in0), .g_in1(s4_in1),
        .g_logic(s4_logic), .g_is_output(1'b0), .g_last(s4_last),
        .mem_we(s4_we), .mem_addr(s4_addr), .mem_wdata(s4_wdata), .done(s4_done),
        .gate_count(s4_gc), .xor_count(s4_xc),
        .err_in0(s4_err_in0), .err_full(s4_err_full)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Expected S=14 gate word from the documented bit layout.
    function automatic logic [31:0] gw14(input int in0, input int in1, input int lg, input int o);
        gw14 = ((32'(in0) & 32'h0000_1FFF) << 19) | ((32'(in1) & 32'h0000_3FFF) << 5)
             | ((32'(lg) & 32'h0000_000F) << 1) | (32'(o) & 32'h0000_0001);
    endfunction

    // Start the S=14 instance and step through the three header cycles.
    task automatic run_header();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        int idx;
        int budget;
        logic v;
        logic rdy;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_we",    32'(mem_we),    32'd0);
        chk("rst_addr",  32'(mem_addr),  32'd0);
        chk("rst_wdata", mem_wdata,      32'd0);
        chk("rst_ready", 32'(g_ready),   32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_counts", {gate_count, xor_count, 2'b00, err_in0, err_full}, 32'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- header ----------------
        init_a = 14'd3; init_b = 14'd5; input_a = 14'd2; input_b = 14'd2;
        dff_size = 14'd0; output_size = 14'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        init_a = 14'd0; init_b = 14'd0; input_a = 14'd0; input_b = 14'd0; output_size = 14'd0;
        chk("hdr0_we",   32'(mem_we),   32'd1);
        chk("hdr0_addr", 32'(mem_addr), 32'd0);
        chk("hdr0_data", mem_wdata,     32'h0000_C005);
        chk("hdr0_rdy",  32'(g_ready),  32'd0);
        tick();
        chk("hdr1_addr", 32'(mem_addr), 32'd1);
        chk("hdr1_data", mem_wdata,     32'h0000_8002);
        tick();
        chk("hdr2_addr", 32'(mem_addr), 32'd2);
        chk("hdr2_data", mem_wdata,     32'h0000_0001);
        chk("hdr2_rdy",  32'(g_ready),  32'd0);
        tick();
        chk("gates_rdy", 32'(g_ready),  32'd1);
        chk("gates_we",  32'(mem_we),   32'd0);

        // ---------------- single gate ----------------
        g_valid = 1'b1; g_in0 = 14'd1; g_in1 = 14'd2; g_logic = 4'b0110;
        g_is_output = 1'b1; g_last = 1'b1;
        tick();
        g_valid = 1'b0; g_last = 1'b0; g_is_output = 1'b0;
        chk("g1_we",   32'(mem_we),     32'd1);
        chk("g1_addr", 32'(mem_addr),   32'd4);
        chk("g1_data", mem_wdata,       32'h0008_004D);
        chk("g1_rdy",  32'(g_ready),    32'd0);
        chk("g1_gc",   32'(gate_count), 32'd1);
        chk("g1_xc",   32'(xor_count),  32'd1);
        tick();
        chk("g1_trl_addr", 32'(mem_addr), 32'd3);
        chk("g1_trl_data", mem_wdata,     32'h0000_4001);
        chk("g1_trl_done", 32'(done),     32'd0);
        tick();
        chk("g1_done",    32'(done),   32'd1);
        chk("g1_done_we", 32'(mem_we), 32'd0);
        tick();
        chk("g1_idle_done", 32'(done),       32'd0);
        chk("g1_hold_gc",   32'(gate_count), 32'd1);

        // ---------------- streaming, 10 back-to-back gates ----------------
        run_header();
        for (int i = 0; i < 10; i++) begin
            g_valid = 1'b1;
            g_in0   = 14'(i);
            g_in1   = 14'(i + 100);
            g_logic = (i % 2 == 0) ? 4'b0001 : 4'b1001;
            g_last  = (i == 9);
            tick();
            chk($sformatf("st_addr%0d", i), 32'(mem_addr), 32'(i + 4));
            chk($sformatf("st_data%0d", i), mem_wdata,
                gw14(i, i + 100, (i % 2 == 0) ? 1 : 9, 0));
            chk($sformatf("st_rdy%0d", i), 32'(g_ready), (i == 9) ? 32'd0 : 32'd1);
        end
        g_valid = 1'b0; g_last = 1'b0;
        tick();
        chk("st_trl_addr", 32'(mem_addr), 32'd3);
        chk("st_trl_data", mem_wdata,     32'h0001_400A);
        tick();
        chk("st_done", 32'(done), 32'd1);
        tick();

        // ---------------- random stalls over 50 gates ----------------
        run_header();
        idx = 0;
        budget = 0;
        while (idx < 50 && budget < 1000) begin
            v = 1'($urandom_range(0, 1));
            rdy = g_ready;
            g_valid = v;
            g_in0   = 14'(idx);
            g_in1   = 14'(idx * 3);
            g_logic = (idx % 3 == 0) ? 4'b0110 : 4'b1000;
            g_is_output = 1'(idx % 2);
            g_last  = (idx == 49);
            tick();
            if (v && rdy) begin
                chk($sformatf("sl_addr%0d", idx), {mem_we, 17'd0, mem_addr}, {1'b1, 17'd0, 14'(idx + 4)});
                chk($sformatf("sl_data%0d", idx), mem_wdata,
                    gw14(idx, idx * 3, (idx % 3 == 0) ? 6 : 8, idx % 2));
                idx = idx + 1;
            end else begin
                chk("sl_idle_we", 32'(mem_we), 32'd0);
            end
            budget = budget + 1;
        end
        chk("sl_budget", 32'(idx), 32'd50);
        g_valid = 1'b0; g_last = 1'b0; g_is_output = 1'b0;
        tick();
        chk("sl_trl_addr", 32'(mem_addr), 32'd3);
        chk("sl_trl_data", mem_wdata,     32'h0004_4032);
        tick();
        chk("sl_done", 32'(done), 32'd1);
        tick();

        // ---------------- in0 top bit error ----------------
        run_header();
        g_valid = 1'b1; g_in0 = 14'h2001; g_in1 = 14'd0; g_logic = 4'd0; g_last = 1'b1;
        tick();
        g_valid = 1'b0; g_last = 1'b0;
        chk("e0_flag", 32'(err_in0),  32'd1);
        chk("e0_full", 32'(err_full), 32'd0);
        chk("e0_data", mem_wdata,     32'h0008_0000);
        tick();
        tick();
        tick();
        chk("e0_sticky", 32'(err_in0), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("e0_clear", 32'(err_in0), 32'd0);
        tick();
        tick();
        tick();

        // ---------------- capacity with S=4 ----------------
        s4_start = 1'b1;
        tick();
        s4_start = 1'b0;
        tick();
        tick();
        tick();
        chk("s4_rdy", 32'(s4_ready), 32'd1);
        for (int i = 0; i < 12; i++) begin
            s4_valid = 1'b1;
            s4_in0   = 4'(i % 8);
            s4_in1   = 4'(i);
            s4_logic = 4'b0001;
            s4_last  = 1'b0;
            tick();
            chk($sformatf("s4_addr%0d", i), 32'(s4_addr), 32'(i + 4));
            chk($sformatf("s4_data%0d", i), s4_wdata,
                (32'(i % 8) << 9) | (32'(i) << 5) | 32'd2);
        end
        chk("s4_full", 32'(s4_err_full), 32'd1);
        chk("s4_rdy_drop", 32'(s4_ready), 32'd0);
        s4_in0 = 4'd1; s4_in1 = 4'd1; s4_last = 1'b1;
        tick();
        chk("s4_trl_addr", 32'(s4_addr),  32'd3);
        chk("s4_trl_data", s4_wdata,      32'h0000_000C);
        s4_valid = 1'b0; s4_last = 1'b0;
        tick();
        chk("s4_done", 32'(s4_done), 32'd1);
        chk("s4_gc",   32'(s4_gc),   32'd12);
        tick();

        // ---------------- reset mid-GATES ----------------
        run_header();
        for (int i = 0; i < 3; i++) begin
            g_valid = 1'b1; g_in0 = 14'd7; g_in1 = 14'd7; g_logic = 4'b0110; g_last = 1'b0;
            tick();
        end
        g_valid = 1'b0;
        chk("mr_gc_before", 32'(gate_count), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("mr_we",  32'(mem_we),     32'd0);
        chk("mr_wd",  mem_wdata,       32'd0);
        chk("mr_rdy", 32'(g_ready),    32'd0);
        chk("mr_gc",  32'(gate_count), 32'd0);
        chk("mr_xc",  32'(xor_count),  32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        init_a = 14'd9; init_b = 14'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mr_hdr_addr", 32'(mem_addr), 32'd0);
        chk("mr_hdr_data", mem_wdata,     32'h0002_4004);
        tick();
        tick();
        tick();
        g_valid = 1'b1; g_in0 = 14'd2; g_in1 = 14'd3; g_logic = 4'b1001; g_last = 1'b1;
        tick();
        g_valid = 1'b0; g_last = 1'b0;
        chk("mr_g_addr", 32'(mem_addr),   32'd4);
        chk("mr_g_data", mem_wdata,       32'h0010_0072);
        chk("mr_g_gc",   32'(gate_count), 32'd1);
        tick();
        chk("mr_trl", mem_wdata, 32'h0000_4001);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
